// File: rtl/srio_link_monitor_if.sv
// Status and statistics bundle between the SRIO example top and its link monitor.
// The master side drives raw status and clr_stats; the slave side is the monitor.
interface srio_link_monitor_if;
    logic        clk_lock_in;
    logic        port_initialized;
    logic        link_initialized;
    logic        mode_1x;
    logic        clr_stats;
    logic        link_up;
    logic        phy_reinit;
    logic [2:0]  state_o;
    logic [15:0] link_drop_cnt;
    logic [7:0]  timeout_cnt;
    logic [3:0]  led;

    modport master (
        output clk_lock_in, port_initialized, link_initialized, mode_1x, clr_stats,
        input  link_up, phy_reinit, state_o, link_drop_cnt, timeout_cnt, led
    );

    modport slave (
        input  clk_lock_in, port_initialized, link_initialized, mode_1x, clr_stats,
        output link_up, phy_reinit, state_o, link_drop_cnt, timeout_cnt, led
    );
endinterface

// File: rtl/srio_link_monitor.sv
// SRIO link bring-up monitor: synchronises and debounces raw PHY status, tracks
// bring-up with an FSM, pulses a PHY re-init on stalls, keeps drop/timeout stats.
module srio_link_monitor #(
    parameter int unsigned DEBOUNCE_CYCLES = 64,
    parameter int unsigned INIT_TIMEOUT    = 1000000,
    parameter int unsigned REINIT_CYCLES   = 16,
    parameter int unsigned BLINK_BIT       = 24
) (
    input  logic                 sys_clk,
    input  logic                 sys_rst,
    srio_link_monitor_if.slave   mon
);

    typedef enum logic [2:0] {
        S_LOCK   = 3'd0,
        S_PORT   = 3'd1,
        S_LINK   = 3'd2,
        S_UP     = 3'd3,
        S_REINIT = 3'd4
    } state_t;

    // Bit order: 0 = clk_lock, 1 = port, 2 = link, 3 = mode_1x
    logic [3:0] raw_status;
    logic [3:0] filt;

    assign raw_status = {mon.mode_1x, mon.link_initialized, mon.port_initialized, mon.clk_lock_in};

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_filter
            logic        sync1_reg;
            logic        sync2_reg;
            logic        filt_reg;
            logic [15:0] deb_cnt_reg;

            always_ff @(posedge sys_clk) begin
                if (sys_rst) begin
                    sync1_reg   <= 1'b0;
                    sync2_reg   <= 1'b0;
                    filt_reg    <= 1'b0;
                    deb_cnt_reg <= 16'd0;
                end else begin
                    sync1_reg <= raw_status[gi];
                    sync2_reg <= sync1_reg;
                    // Only a run of DEBOUNCE_CYCLES consecutive disagreeing samples flips the bit
                    if (sync2_reg == filt_reg) begin
                        deb_cnt_reg <= 16'd0;
                    end else if (deb_cnt_reg == 16'(DEBOUNCE_CYCLES - 1)) begin
                        filt_reg    <= sync2_reg;
                        deb_cnt_reg <= 16'd0;
                    end else begin
                        deb_cnt_reg <= deb_cnt_reg + 16'd1;
                    end
                end
            end

            assign filt[gi] = filt_reg;
        end
    endgenerate

    logic f_clk_lock, f_port, f_link, f_mode_1x;
    assign f_clk_lock = filt[0];
    assign f_port     = filt[1];
    assign f_link     = filt[2];
    assign f_mode_1x  = filt[3];

    state_t      state_reg, state_next;
    logic [31:0] timer_reg, timer_next;
    logic [7:0]  reinit_cnt_reg, reinit_cnt_next;
    logic        drop_inc, timeout_inc, init_expired;

    assign init_expired = (timer_reg == 32'(INIT_TIMEOUT - 1));

    always_comb begin
        state_next = state_reg;
        drop_inc   = 1'b0;
        case (state_reg)
            S_LOCK: begin
                if (f_clk_lock)
                    state_next = S_PORT;
            end
            S_PORT: begin
                if (!f_clk_lock)
                    state_next = S_LOCK;
                else if (f_port)
                    state_next = S_LINK;
                else if (init_expired)
                    state_next = S_REINIT;
            end
            S_LINK: begin
                if (!f_clk_lock)
                    state_next = S_LOCK;
                else if (f_link && f_port)
                    state_next = S_UP;
                else if (!f_port)
                    state_next = S_PORT;
                else if (init_expired)
                    state_next = S_REINIT;
            end
            S_UP: begin
                if (!f_clk_lock) begin
                    state_next = S_LOCK;
                end else if (!f_port || !f_link) begin
                    state_next = S_PORT;
                    drop_inc   = 1'b1;
                end
            end
            S_REINIT: begin
                if (reinit_cnt_reg == 8'(REINIT_CYCLES - 1))
                    state_next = S_LOCK;
            end
            default: state_next = S_LOCK;
        endcase
    end

    assign timeout_inc = (state_next == S_REINIT) && (state_reg != S_REINIT);

    // The init timer spans S_PORT and S_LINK together, so a LINK->PORT fallback keeps it running
    always_comb begin
        timer_next      = 32'd0;
        reinit_cnt_next = 8'd0;
        if (state_reg == S_PORT || state_reg == S_LINK)
            timer_next = timer_reg + 32'd1;
        if (state_reg == S_REINIT)
            reinit_cnt_next = reinit_cnt_reg + 8'd1;
    end

    logic [15:0] link_drop_cnt_reg;
    logic [7:0]  timeout_cnt_reg;
    logic [31:0] free_cnt_reg;
    logic        link_up_reg;
    logic        phy_reinit_reg;
    logic [3:0]  led_reg;

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            state_reg         <= S_LOCK;
            timer_reg         <= 32'd0;
            reinit_cnt_reg    <= 8'd0;
            link_drop_cnt_reg <= 16'd0;
            timeout_cnt_reg   <= 8'd0;
            free_cnt_reg      <= 32'd0;
            link_up_reg       <= 1'b0;
            phy_reinit_reg    <= 1'b0;
            led_reg           <= 4'd0;
        end else begin
            state_reg      <= state_next;
            timer_reg      <= timer_next;
            reinit_cnt_reg <= reinit_cnt_next;
            free_cnt_reg   <= free_cnt_reg + 32'd1;

            if (mon.clr_stats)
                link_drop_cnt_reg <= 16'd0;
            else if (drop_inc && link_drop_cnt_reg != 16'hFFFF)
                link_drop_cnt_reg <= link_drop_cnt_reg + 16'd1;

            if (mon.clr_stats)
                timeout_cnt_reg <= 8'd0;
            else if (timeout_inc && timeout_cnt_reg != 8'hFF)
                timeout_cnt_reg <= timeout_cnt_reg + 8'd1;

            // Status outputs trail the state register by one cycle
            link_up_reg    <= (state_reg == S_UP);
            phy_reinit_reg <= (state_reg == S_REINIT);
            if (state_reg == S_REINIT)
                led_reg <= {4{free_cnt_reg[BLINK_BIT]}};
            else
                led_reg <= {f_clk_lock, (state_reg == S_UP), f_port, !f_mode_1x};
        end
    end

    logic unused_free_bits;
    assign unused_free_bits = ^free_cnt_reg;

    assign mon.state_o       = state_reg;
    assign mon.link_up       = link_up_reg;
    assign mon.phy_reinit    = phy_reinit_reg;
    assign mon.link_drop_cnt = link_drop_cnt_reg;
    assign mon.timeout_cnt   = timeout_cnt_reg;
    assign mon.led           = led_reg;

endmodule

// File: tb/tb_srio_link_monitor.sv
// Directed bench for srio_link_monitor: expectations are queued as stimulus is
// applied and popped against the DUT outputs at the following check point.
module tb_srio_link_monitor;

    localparam int SEL_STATE = 0;
    localparam int SEL_LUP   = 1;
    localparam int SEL_PHY   = 2;
    localparam int SEL_DROP  = 3;
    localparam int SEL_TOUT  = 4;
    localparam int SEL_LED   = 5;

    typedef struct {
        string       tag;
        int          sel;
        logic [31:0] val;
    } exp_t;

    logic sys_clk = 1'b0;
    logic sys_rst = 1'b1;
    logic [31:0] tb_free = 32'd0;
    int n_assert = 0;
    int n_fail   = 0;
    exp_t sb[$];

    srio_link_monitor_if mon_if ();

    srio_link_monitor #(
        .DEBOUNCE_CYCLES(4),
        .INIT_TIMEOUT(100),
        .REINIT_CYCLES(8),
        .BLINK_BIT(2)
    ) dut (
        .sys_clk(sys_clk),
        .sys_rst(sys_rst),
        .mon(mon_if)
    );

    always #5 sys_clk = ~sys_clk;

    // Reference free-running counter used to predict the blink bit
    always @(posedge sys_clk) tb_free <= sys_rst ? 32'd0 : tb_free + 32'd1;

    task automatic tick(input int n);
        repeat (n) @(posedge sys_clk);
        @(negedge sys_clk);
    endtask

    task automatic push(input string tag, input int sel, input logic [31:0] v);
        exp_t e;
        e.tag = tag;
        e.sel = sel;
        e.val = v;
        sb.push_back(e);
    endtask

    function automatic logic [31:0] observe(input int sel);
        case (sel)
            SEL_STATE: return {29'd0, mon_if.state_o};
            SEL_LUP:   return {31'd0, mon_if.link_up};
            SEL_PHY:   return {31'd0, mon_if.phy_reinit};
            SEL_DROP:  return {16'd0, mon_if.link_drop_cnt};
            SEL_TOUT:  return {24'd0, mon_if.timeout_cnt};
            default:   return {28'd0, mon_if.led};
        endcase
    endfunction

    task automatic check_all();
        exp_t e;
        logic [31:0] obs;
        while (sb.size() > 0) begin
            e = sb.pop_front();
            obs = observe(e.sel);
            n_assert++;
            assert (obs === e.val) else begin
                n_fail++;
                $error("FAIL %s: observed 0x%0h expected 0x%0h", e.tag, obs, e.val);
            end
        end
    endtask

    initial begin
        logic [31:0] fb;
        int budget;

        mon_if.clk_lock_in      = 1'b0;
        mon_if.port_initialized = 1'b0;
        mon_if.link_initialized = 1'b0;
        mon_if.mode_1x          = 1'b0;
        mon_if.clr_stats        = 1'b0;

        // Reset
        sys_rst = 1'b1;
        tick(10);
        push("rst_state", SEL_STATE, 0); push("rst_lup", SEL_LUP, 0); push("rst_phy", SEL_PHY, 0);
        push("rst_drop", SEL_DROP, 0);   push("rst_tout", SEL_TOUT, 0); push("rst_led", SEL_LED, 0);
        check_all();
        sys_rst = 1'b0;
        tick(2);

        // Normal bring-up: each step lands 7 cycles after its input edge
        mon_if.clk_lock_in = 1'b1;
        tick(6); push("lock_pre", SEL_STATE, 0); check_all();
        tick(1); push("lock_step", SEL_STATE, 1); check_all();
        tick(13);
        mon_if.port_initialized = 1'b1;
        tick(6); push("port_pre", SEL_STATE, 1); check_all();
        tick(1); push("port_step", SEL_STATE, 2); check_all();
        tick(13);
        mon_if.link_initialized = 1'b1;
        tick(6); push("link_pre", SEL_STATE, 2); check_all();
        tick(1); push("link_step", SEL_STATE, 3); check_all();
        tick(2);
        push("up_lup", SEL_LUP, 1); push("up_led", SEL_LED, 4'b1111); push("up_drop", SEL_DROP, 0);
        check_all();

        // mode_1x shows on led[0] inverted
        mon_if.mode_1x = 1'b1;
        tick(8); push("mode1x_led", SEL_LED, 4'b1110); check_all();
        mon_if.mode_1x = 1'b0;
        tick(8);

        // Glitch rejection: 3-cycle drop ignored, 4-cycle drop honoured
        mon_if.link_initialized = 1'b0;
        tick(3);
        mon_if.link_initialized = 1'b1;
        tick(10); push("glitch3_state", SEL_STATE, 3); push("glitch3_drop", SEL_DROP, 0); check_all();
        mon_if.link_initialized = 1'b0;
        tick(4);
        mon_if.link_initialized = 1'b1;
        tick(2); push("glitch4_pre", SEL_STATE, 3); check_all();
        tick(1); push("glitch4_state", SEL_STATE, 1); push("glitch4_drop", SEL_DROP, 1); check_all();
        tick(10); push("restore_state", SEL_STATE, 3); push("restore_lup", SEL_LUP, 1); check_all();

        // Lock loss overrides link loss and is not counted as a drop
        mon_if.clk_lock_in      = 1'b0;
        mon_if.link_initialized = 1'b0;
        tick(6); push("lockloss_pre", SEL_STATE, 3); check_all();
        tick(1); push("lockloss_state", SEL_STATE, 0); push("lockloss_drop", SEL_DROP, 1); check_all();
        mon_if.port_initialized = 1'b0;
        tick(10);

        // Timeout: exactly 100 cycles in S_PORT, then an 8-cycle re-init pulse
        mon_if.clk_lock_in = 1'b1;
        tick(7); push("to_port", SEL_STATE, 1); check_all();
        tick(99); push("to_pre", SEL_STATE, 1); check_all();
        tick(1);
        push("to_state", SEL_STATE, 4); push("to_cnt", SEL_TOUT, 1); push("to_phy_lag", SEL_PHY, 0);
        push("to_led_lag", SEL_LED, 4'b1001);
        check_all();
        for (int i = 0; i < 8; i++) begin
            tick(1);
            fb = tb_free - 32'd1;
            push("reinit_phy", SEL_PHY, 1);
            push("reinit_led", SEL_LED, {28'd0, {4{fb[2]}}});
            push("reinit_state", SEL_STATE, (i == 7) ? 0 : 4);
            check_all();
        end
        tick(1); push("reinit_end_phy", SEL_PHY, 0); push("reinit_relock", SEL_STATE, 1); check_all();

        // Saturation of timeout_cnt
        budget = 0;
        while (mon_if.timeout_cnt != 8'hFF && budget < 40000) begin
            tick(1);
            budget++;
        end
        push("sat_reach", SEL_TOUT, 8'hFF); check_all();
        tick(250); push("sat_hold", SEL_TOUT, 8'hFF); check_all();

        // Align to a REINIT entry edge, then clear on the next entry
        budget = 0;
        while (mon_if.state_o == 3'd4 && budget < 300) begin tick(1); budget++; end
        budget = 0;
        while (mon_if.state_o != 3'd4 && budget < 300) begin tick(1); budget++; end
        push("align_state", SEL_STATE, 4); check_all();
        tick(108);
        mon_if.clr_stats = 1'b1;
        tick(1);
        mon_if.clr_stats = 1'b0;
        push("clr_state", SEL_STATE, 4); push("clr_tout", SEL_TOUT, 0); push("clr_drop", SEL_DROP, 0);
        check_all();

        // Reset three cycles into S_REINIT
        tick(109); push("next_to_state", SEL_STATE, 4); push("next_to_cnt", SEL_TOUT, 1); check_all();
        tick(2); push("mid_phy", SEL_PHY, 1); check_all();
        sys_rst = 1'b1;
        tick(1);
        push("mrst_phy", SEL_PHY, 0); push("mrst_state", SEL_STATE, 0); push("mrst_tout", SEL_TOUT, 0);
        push("mrst_drop", SEL_DROP, 0); push("mrst_led", SEL_LED, 0); push("mrst_lup", SEL_LUP, 0);
        check_all();
        sys_rst = 1'b0;
        tick(2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
